// File: rtl/motor_sync_multi_if.sv
// rtl/motor_sync_multi_if.sv - control, strobe and stretched-output bundle for motor_sync_multi
interface motor_sync_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 11
);
  logic                enable;
  logic [CNT_W-1:0]    hold_cycles;
  logic                retrig;
  logic                edge_mode;
  logic [CHANNELS-1:0] signal_in;
  logic [CHANNELS-1:0] long_signal;
  logic [CHANNELS-1:0] done_pulse;
  logic                any_active;

  modport master (
    output enable, hold_cycles, retrig, edge_mode, signal_in,
    input  long_signal, done_pulse, any_active
  );

  modport slave (
    input  enable, hold_cycles, retrig, edge_mode, signal_in,
    output long_signal, done_pulse, any_active
  );
endinterface

// File: rtl/motor_sync_multi.sv
// rtl/motor_sync_multi.sv - multi-channel synchronised, retriggerable pulse stretcher
module motor_sync_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  motor_sync_multi_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  sync_dly_q, sync_dly_d;
  state_t                               state_q [CHANNELS];
  state_t                               state_d [CHANNELS];
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  // Set once the count has started falling; closes the one-shot continuation window.
  logic [CHANNELS-1:0]                  run_q, run_d;
  logic [CHANNELS-1:0]                  long_q, long_d;
  logic [CHANNELS-1:0]                  done_q, done_d;
  logic                                 any_q, any_d;
  logic [CHANNELS-1:0]                  sync, trig;

  // Shift each synchroniser chain and derive the per-channel trigger
  always_comb begin
    sync_d = sync_q;
    sync   = '0;
    trig   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], bus.signal_in[ch]};
      sync[ch]   = sync_q[ch][SYNC_STAGES-1];
      trig[ch]   = bus.edge_mode ? (sync[ch] & ~sync_dly_q[ch]) : sync[ch];
    end
    // Edge history keeps tracking while disabled so a stale edge never fires.
    sync_dly_d = sync;
  end

  // Next state of every channel's stretch FSM; enable low forces a silent clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    long_d  = long_q;
    done_d  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (!bus.enable) begin
        state_d[ch] = IDLE;
        cnt_d[ch]   = '0;
        run_d[ch]   = 1'b0;
        long_d[ch]  = 1'b0;
      end else begin
        case (state_q[ch])
          IDLE: begin
            if (trig[ch]) begin
              state_d[ch] = ACTIVE;
              cnt_d[ch]   = bus.hold_cycles;
              run_d[ch]   = 1'b0;
              long_d[ch]  = 1'b1;
            end
          end
          ACTIVE: begin
            if (trig[ch] && bus.retrig) begin
              cnt_d[ch] = bus.hold_cycles;
              run_d[ch] = 1'b0;
            end else if (trig[ch] && !run_q[ch] && (cnt_q[ch] != '0)) begin
              // One-shot: still inside the initial high period, keep the count topped up.
              cnt_d[ch] = bus.hold_cycles;
            end else if (cnt_q[ch] != '0) begin
              cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
              run_d[ch] = 1'b1;
            end else begin
              state_d[ch] = IDLE;
              run_d[ch]   = 1'b0;
              long_d[ch]  = 1'b0;
              done_d[ch]  = 1'b1;
            end
          end
          default: state_d[ch] = IDLE;
        endcase
      end
    end
    any_d = |long_d;
  end

  // Register synchronisers, channel state and all outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      sync_dly_q <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      long_q     <= '0;
      done_q     <= '0;
      any_q      <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
      end
    end else begin
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      long_q     <= long_d;
      done_q     <= done_d;
      any_q      <= any_d;
      state_q    <= state_d;
    end
  end

  assign bus.long_signal = long_q;
  assign bus.done_pulse  = done_q;
  assign bus.any_active  = any_q;

endmodule

// File: tb/tb_motor_sync_multi.sv
// tb/tb_motor_sync_multi.sv - directed vector and sequence bench for motor_sync_multi
module tb_motor_sync_multi;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  motor_sync_multi_if #(.CHANNELS(4), .CNT_W(11)) ifc ();

  motor_sync_multi #(.CHANNELS(4), .CNT_W(11), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [10:0] hold;
    logic        rt;
    logic        em;
    logic [3:0]  sig;
    logic [3:0]  exp_long;
    logic [3:0]  exp_done;
    logic        exp_any;
  } vec_t;

  vec_t        vecs[$];
  logic        ph_en;
  logic [10:0] ph_hold;
  logic        ph_rt;
  logic        ph_em;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic [3:0] l, input logic [3:0] d, input logic a);
    vec_t v;
    v.en = ph_en; v.hold = ph_hold; v.rt = ph_rt; v.em = ph_em;
    v.sig = s; v.exp_long = l; v.exp_done = d; v.exp_any = a;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    ifc.signal_in = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive up to two pulses on one channel and measure the resulting stretch.
  task automatic run_pulses(input string name, input int ch, input logic em, input logic rt,
                            input logic [10:0] h0, input int chg_at, input logic [10:0] h1,
                            input int p1s, input int p1l, input int p2s, input int p2l, input int n,
                            input int exp_rise, input int exp_width, input int exp_rises,
                            input int exp_dones);
    int   first_rise, width, rises, dones, bad;
    logic prev, cur;
    logic [3:0] s;
    first_rise = -1; width = 0; rises = 0; dones = 0; bad = 0; prev = 1'b0;
    ifc.enable = 1'b1; ifc.edge_mode = em; ifc.retrig = rt; ifc.hold_cycles = h0;
    for (int t = 0; t < n; t++) begin
      if (t == chg_at) ifc.hold_cycles = h1;
      s = '0;
      s[ch] = ((t >= p1s) && (t < p1s + p1l)) || ((t >= p2s) && (t < p2s + p2l));
      ifc.signal_in = s;
      tick();
      cur = ifc.long_signal[ch];
      if (cur && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = t;
      end
      if (cur) width++;
      if (ifc.done_pulse[ch]) dones++;
      if (ifc.done_pulse[ch] != (prev && !cur)) bad++;
      if (ifc.any_active != (|ifc.long_signal)) bad++;
      prev = cur;
    end
    idle(5);
    check({name, "_rise"},  first_rise, exp_rise);
    check({name, "_width"}, width, exp_width);
    check({name, "_rises"}, rises, exp_rises);
    check({name, "_dones"}, dones, exp_dones);
    check({name, "_align"}, bad, 0);
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ifc.enable = 1'b0; ifc.hold_cycles = '0; ifc.retrig = 1'b0;
    ifc.edge_mode = 1'b0; ifc.signal_in = '0;

    // Level mode, hold 0: long follows sync one cycle later, ch0 and ch2 independent.
    ph_en = 1'b1; ph_hold = 11'd0; ph_rt = 1'b1; ph_em = 1'b0;
    add(4'b0101, 4'b0000, 4'b0000, 1'b0);
    add(4'b0100, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 4'b0101, 4'b0000, 1'b1);
    add(4'b0001, 4'b0100, 4'b0001, 1'b1);
    add(4'b0000, 4'b0001, 4'b0100, 1'b1);
    add(4'b0000, 4'b0001, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    // Edge mode, hold 2, ch1: one trigger per rising edge, 3-cycle stretch each.
    ph_hold = 11'd2; ph_em = 1'b1;
    add(4'b0010, 4'b0000, 4'b0000, 1'b0);
    add(4'b0010, 4'b0000, 4'b0000, 1'b0);
    add(4'b0010, 4'b0010, 4'b0000, 1'b1);
    add(4'b0000, 4'b0010, 4'b0000, 1'b1);
    add(4'b0010, 4'b0010, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b0010, 1'b0);
    add(4'b0000, 4'b0010, 4'b0000, 1'b1);
    add(4'b0000, 4'b0010, 4'b0000, 1'b1);
    add(4'b0000, 4'b0010, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b0010, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    // One-shot edge mode, hold 3, ch3: mid-stretch edge ignored, later edge relaunches.
    ph_hold = 11'd3; ph_rt = 1'b0;
    add(4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b1000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b1000, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 3; i++) tick();
    check("reset_long", ifc.long_signal, 0);
    check("reset_done", ifc.done_pulse, 0);
    check("reset_any",  ifc.any_active, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      ifc.enable = vecs[i].en; ifc.hold_cycles = vecs[i].hold;
      ifc.retrig = vecs[i].rt; ifc.edge_mode = vecs[i].em; ifc.signal_in = vecs[i].sig;
      tick();
      check($sformatf("vec%0d_long", i), ifc.long_signal, vecs[i].exp_long);
      check($sformatf("vec%0d_done", i), ifc.done_pulse, vecs[i].exp_done);
      check($sformatf("vec%0d_any", i),  ifc.any_active, vecs[i].exp_any);
    end
    idle(5);

    run_pulses("lat_level",   0, 1'b0, 1'b1, 11'd10,   -1, 11'd0, 0, 4,  -1, 0, 30,   2, 14,   1, 1);
    run_pulses("edge_held",   1, 1'b1, 1'b1, 11'd5,    -1, 11'd0, 0, 50, -1, 0, 60,   2, 6,    1, 1);
    run_pulses("retrig_on",   2, 1'b1, 1'b1, 11'd20,   -1, 11'd0, 0, 2,  15, 2, 60,   2, 36,   1, 1);
    run_pulses("retrig_off",  2, 1'b1, 1'b0, 11'd20,   -1, 11'd0, 0, 2,  15, 2, 60,   2, 21,   1, 1);
    run_pulses("relaunch",    2, 1'b1, 1'b0, 11'd20,   -1, 11'd0, 0, 2,  30, 2, 70,   2, 42,   2, 2);
    run_pulses("hold_zero",   3, 1'b1, 1'b1, 11'd0,    -1, 11'd0, 0, 3,  -1, 0, 10,   2, 1,    1, 1);
    run_pulses("hold_max",    0, 1'b1, 1'b1, 11'd2047, -1, 11'd0, 0, 1,  -1, 0, 2060, 2, 2048, 1, 1);
    run_pulses("hold_change", 1, 1'b1, 1'b1, 11'd100,  10, 11'd3, 0, 1,  -1, 0, 120,  2, 101,  1, 1);

    // Enable dropped mid-stretch on all channels: silent clear next edge.
    ifc.enable = 1'b1; ifc.edge_mode = 1'b0; ifc.retrig = 1'b1; ifc.hold_cycles = 11'd50;
    ifc.signal_in = 4'hF;
    tick();
    ifc.signal_in = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    check("en_pre_long", ifc.long_signal, 4'hF);
    ifc.enable = 1'b0;
    tick();
    check("en_off_long", ifc.long_signal, 0);
    check("en_off_done", ifc.done_pulse, 0);
    check("en_off_any",  ifc.any_active, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((ifc.done_pulse != 0) || (ifc.long_signal != 0)) cnt++;
    end
    check("en_off_quiet", cnt, 0);
    ifc.edge_mode = 1'b1;
    ifc.signal_in = 4'hF;
    for (int i = 0; i < 4; i++) tick();
    ifc.enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.long_signal != 0) cnt++;
    end
    check("stale_edge", cnt, 0);
    ifc.signal_in = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    ifc.signal_in = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    check("reenable_fire", ifc.long_signal, 4'hF);
    idle(60);

    // Asynchronous reset between edges mid-count.
    ifc.edge_mode = 1'b1; ifc.hold_cycles = 11'd50;
    ifc.signal_in = 4'h1;
    tick();
    ifc.signal_in = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    check("arst_pre_long", ifc.long_signal, 4'h1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_long", ifc.long_signal, 0);
    check("arst_done", ifc.done_pulse, 0);
    check("arst_any",  ifc.any_active, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((ifc.long_signal != 0) || (ifc.done_pulse != 0) || ifc.any_active) cnt++;
    end
    check("arst_no_resume", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
